// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and address helper for the NTT sequencer.
package ntt_pkg;

  localparam int unsigned KYBER_N      = 256;
  localparam int unsigned NUM_LAYERS   = 7;
  localparam int unsigned BF_PER_LAYER = 128;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } seq_state_e;

  // Lower address of butterfly b when the pair distance is 2**span_log.
  // The group index selects a 2*len block and the offset picks the slot inside it.
  function automatic logic [7:0] bf_addr_a(input logic [6:0] b, input logic [2:0] span_log);
    logic [7:0] mask;
    logic [7:0] grp;
    logic [7:0] ofs;
    mask = (8'd1 << span_log) - 8'd1;
    ofs  = {1'b0, b} & mask;
    grp  = {1'b0, b} >> span_log;
    return (grp << ({1'b0, span_log} + 4'd1)) | ofs;
  endfunction

endpackage

// File: rtl/ntt_seq_delay.sv
// Fixed-depth shift register that aligns write-back strobes with the butterfly pipeline.
// Shifts every cycle; asynchronous reset clears every stage.
module ntt_seq_delay #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  // Shift chain; stage 0 captures the issue side each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/ntt_sequencer.sv
// Address/control sequencer for a 256-point Kyber NTT/INTT: issues 128 butterflies per
// layer over 7 layers, then drains the datapath before the next layer.
// Optional feature: define NTT_SEQ_PERF_EN to enable the busy-cycle counter on cycle_cnt.
module ntt_sequencer
  import ntt_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ZETA_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_ntt,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ZETA_W-1:0] zeta_addr,
  output logic [2:0]        layer,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [15:0]       cycle_cnt
);

  localparam logic [6:0] LastBf    = 7'(BF_PER_LAYER - 1);
  localparam logic [2:0] LastLayer = 3'(NUM_LAYERS - 1);
  localparam logic [3:0] DrainLast = 4'(PIPE_LAT - 1);

  seq_state_e state_q, state_d;
  logic [6:0] b_q;
  logic [2:0] layer_q;
  logic [3:0] drain_q;
  logic       mode_q;
  logic       done_q;
  logic       drain_end;

  logic [2:0] span_log;
  logic [7:0] grp;
  logic [7:0] addr_a8;
  logic [7:0] addr_b8;
  logic [7:0] zeta8;

  assign drain_end = (state_q == StDrain) && (drain_q == DrainLast);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; stall only matters while issuing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (!stall && (b_q == LastBf)) state_d = StDrain;
      StDrain: if (drain_end) state_d = (layer_q == LastLayer) ? StIdle : StIssue;
      default: state_d = StIdle;
    endcase
  end

  // Butterfly, layer and drain counters plus the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      layer_q <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= is_ntt;
            b_q     <= '0;
            layer_q <= '0;
            drain_q <= '0;
          end
        end
        // b wraps 127 -> 0 on the last issue, ready for the next layer.
        StIssue: if (!stall) b_q <= b_q + 7'd1;
        StDrain: begin
          if (drain_end) begin
            drain_q <= '0;
            layer_q <= (layer_q == LastLayer) ? 3'd0 : layer_q + 3'd1;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        default: ;
      endcase
      done_q <= drain_end && (layer_q == LastLayer);
    end
  end

  // Butterfly geometry: NTT halves the pair distance per layer, INTT doubles it.
  always_comb begin
    span_log = mode_q ? (3'd7 - layer_q) : (layer_q + 3'd1);
    grp      = {1'b0, b_q} >> span_log;
    addr_a8  = bf_addr_a(b_q, span_log);
    addr_b8  = addr_a8 + (8'd1 << span_log);
    zeta8    = mode_q ? ((8'd1 << layer_q) + grp) : ((8'd128 >> layer_q) - 8'd1 - grp);
  end

  // Outputs; everything on the issue side reads zero while idle.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    rd_valid  = (state_q == StIssue) && !stall;
    rd_addr_a = '0;
    rd_addr_b = '0;
    zeta_addr = '0;
    layer     = '0;
    if (busy) begin
      rd_addr_a = ADDR_W'(addr_a8);
      rd_addr_b = ADDR_W'(addr_b8);
      zeta_addr = ZETA_W'(zeta8);
      layer     = layer_q;
    end
  end

  ntt_seq_delay #(
    .Depth (PIPE_LAT),
    .Width (1 + 2 * ADDR_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({rd_valid, rd_addr_a, rd_addr_b}),
    .dout  ({wr_en, wr_addr_a, wr_addr_b})
  );

`ifdef NTT_SEQ_PERF_EN
  logic [15:0] cnt_q;

  // Busy-cycle counter: cleared when a start is accepted, saturates, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
